// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: byte stream in, padded 32-bit big-endian words out,
// 16 per block with word index and final-block flag for the round stage.
module sha256_msg_padder #(
    parameter int LEN_W = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    input  logic        in_empty,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_word,
    output logic [3:0]  out_idx,
    output logic        out_blk_last,
    input  logic        out_ready,
    output logic        busy
);
    typedef enum logic [1:0] {S_DATA, S_PAD, S_ZERO, S_LEN} state_t;

    state_t             state_reg, state_next;
    logic [5:0]         pos_reg;
    logic [LEN_W-1:0]   cnt_reg, cnt_next;
    logic [23:0]        acc_reg;
    logic [31:0]        out_word_reg;
    logic               out_valid_reg;
    logic [3:0]         out_idx_reg;
    logic               out_blk_last_reg;
    logic               busy_reg;
    logic               last_flag_reg;

    logic               advance;
    logic               byte_en;
    logic [7:0]         byte_val;
    logic               cur_set;
    logic               wrap_set;
    logic               flag_clr;
    logic               in_ready_c;
    logic               word_load;
    logic [63:0]        len64;
    logic [2:0]         len_sel;

    assign len64   = 64'(cnt_reg);
    assign len_sel = ~pos_reg[2:0];
    assign advance = !(pos_reg[1:0] == 2'd3 && out_valid_reg && !out_ready);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        byte_en    = 1'b0;
        byte_val   = 8'h00;
        cur_set    = 1'b0;
        wrap_set   = 1'b0;
        flag_clr   = 1'b0;
        in_ready_c = 1'b0;
        case (state_reg)
            S_DATA: begin
                in_ready_c = advance;
                if (in_valid && advance) begin
                    if (!(in_last && in_empty)) begin
                        byte_en  = 1'b1;
                        byte_val = in_data;
                        cnt_next = cnt_reg + LEN_W'(8);
                    end
                    if (in_last) state_next = S_PAD;
                end
            end
            S_PAD: begin
                if (advance) begin
                    byte_en    = 1'b1;
                    byte_val   = 8'h80;
                    cur_set    = (pos_reg <= 6'd55);
                    wrap_set   = (pos_reg == 6'd63);
                    state_next = S_ZERO;
                end
            end
            S_ZERO: begin
                if (pos_reg == 6'd56) begin
                    state_next = S_LEN;
                    wrap_set   = 1'b1;
                end else if (advance) begin
                    byte_en  = 1'b1;
                    // Wrapping here means the next block carries the length,
                    // so it is flagged final from its first word.
                    wrap_set = (pos_reg == 6'd63);
                end
            end
            S_LEN: begin
                if (advance) begin
                    byte_en  = 1'b1;
                    byte_val = len64[{len_sel, 3'b000} +: 8];
                    if (pos_reg == 6'd63) begin
                        state_next = S_DATA;
                        cnt_next   = '0;
                        flag_clr   = 1'b1;
                    end
                end
            end
            default: state_next = S_DATA;
        endcase
    end

    assign word_load = byte_en && (pos_reg[1:0] == 2'd3);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg        <= S_DATA;
            pos_reg          <= '0;
            cnt_reg          <= '0;
            acc_reg          <= '0;
            out_word_reg     <= '0;
            out_valid_reg    <= 1'b0;
            out_idx_reg      <= '0;
            out_blk_last_reg <= 1'b0;
            busy_reg         <= 1'b0;
            last_flag_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (byte_en) begin
                acc_reg <= {acc_reg[15:0], byte_val};
                pos_reg <= pos_reg + 6'd1;
            end
            if (word_load) begin
                out_word_reg     <= {acc_reg, byte_val};
                out_idx_reg      <= pos_reg[5:2];
                out_blk_last_reg <= last_flag_reg | cur_set;
                out_valid_reg    <= 1'b1;
            end else if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
                if (out_idx_reg == 4'd15) out_blk_last_reg <= 1'b0;
            end
            if (flag_clr)
                last_flag_reg <= 1'b0;
            else if (cur_set || wrap_set)
                last_flag_reg <= 1'b1;
            if (in_valid && in_ready_c)
                busy_reg <= 1'b1;
            else if (out_valid_reg && out_ready && out_idx_reg == 4'd15 && out_blk_last_reg)
                busy_reg <= 1'b0;
        end
    end

    assign in_ready     = rst_n && in_ready_c;
    assign out_valid    = out_valid_reg;
    assign out_word     = out_word_reg;
    assign out_idx      = out_idx_reg;
    assign out_blk_last = out_blk_last_reg;
    assign busy         = busy_reg;
endmodule
